// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core
// Modular exponentiation engine: result = message^exponent mod n.
// Uses left-to-right square-and-multiply over every exponent bit (no
// leading-zero skip), so latency depends only on WIDTH and popcount(exponent).
// Each modular multiply is an interleaved shift-add that runs for exactly
// WIDTH cycles and scans the multiplier MSB first.

module rsa_modexp_core #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] message,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             error
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]    TOP_IDX = IW'(WIDTH - 1);
    localparam logic [IW-1:0]    IDX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0]    IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SQR  = 3'd2,
        S_MUL  = 3'd3,
        S_NEXT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // One interleaved shift-add step of p*y mod m. The partial product p and
    // the addend x are both below m, so every intermediate fits in WIDTH+1
    // bits and a single conditional subtract restores p < m.
    function automatic logic [WIDTH-1:0] mod_step(
        input logic [WIDTH-1:0] p,
        input logic [WIDTH-1:0] x,
        input logic             ybit,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH:0] t;
        t = {p, 1'b0};
        if (t >= {1'b0, m}) begin
            t = t - {1'b0, m};
        end else begin
            t = t;
        end
        if (ybit) begin
            t = t + {1'b0, x};
            if (t >= {1'b0, m}) begin
                t = t - {1'b0, m};
            end else begin
                t = t;
            end
        end else begin
            t = t;
        end
        return t[WIDTH-1:0];
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] base_r, base_s;
    logic [WIDTH-1:0] exp_r, exp_s;
    logic [WIDTH-1:0] n_r, n_s;
    logic [WIDTH-1:0] acc_r, acc_s;
    logic [WIDTH-1:0] x_r, x_s;
    logic [WIDTH-1:0] y_r, y_s;
    logic [WIDTH-1:0] p_r, p_s;
    logic [IW-1:0]    idx_r, idx_s;
    logic [IW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic             done_r, done_s;
    logic             busy_r, busy_s;
    logic             error_r, error_s;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] one_mod_s;

    assign result = result_r;
    assign done   = done_r;
    assign busy   = busy_r;
    assign error  = error_r;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= S_IDLE;
            base_r   <= ZERO;
            exp_r    <= ZERO;
            n_r      <= ZERO;
            acc_r    <= ZERO;
            x_r      <= ZERO;
            y_r      <= ZERO;
            p_r      <= ZERO;
            idx_r    <= IDX_ZERO;
            cnt_r    <= IDX_ZERO;
            result_r <= ZERO;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            base_r   <= base_s;
            exp_r    <= exp_s;
            n_r      <= n_s;
            acc_r    <= acc_s;
            x_r      <= x_s;
            y_r      <= y_s;
            p_r      <= p_s;
            idx_r    <= idx_s;
            cnt_r    <= cnt_s;
            result_r <= result_s;
            done_r   <= done_s;
            busy_r   <= busy_s;
            error_r  <= error_s;
        end
    end

    // Next-state and datapath update for the square-and-multiply sequencer.
    always_comb begin
        state_s  = state_r;
        base_s   = base_r;
        exp_s    = exp_r;
        n_s      = n_r;
        acc_s    = acc_r;
        x_s      = x_r;
        y_s      = y_r;
        p_s      = p_r;
        idx_s    = idx_r;
        cnt_s    = cnt_r;
        result_s = result_r;
        done_s   = 1'b0;
        busy_s   = busy_r;
        error_s  = error_r;

        step_s    = mod_step(p_r, x_r, y_r[WIDTH-1], n_r);
        one_mod_s = (n_r == ONE) ? ZERO : ONE;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    base_s  = message;
                    exp_s   = exponent;
                    n_s     = n;
                    acc_s   = ONE;
                    idx_s   = TOP_IDX;
                    busy_s  = 1'b1;
                    error_s = 1'b0;
                    state_s = S_LOAD;
                end else begin
                    state_s = S_IDLE;
                end
            end

            S_LOAD: begin
                if ((n_r == ZERO) || (base_r >= n_r)) begin
                    error_s  = 1'b1;
                    result_s = ZERO;
                    done_s   = 1'b1;
                    state_s  = S_DONE;
                end else begin
                    // 1 mod n is 0 only for n == 1.
                    acc_s   = one_mod_s;
                    x_s     = one_mod_s;
                    y_s     = one_mod_s;
                    p_s     = ZERO;
                    cnt_s   = TOP_IDX;
                    state_s = S_SQR;
                end
            end

            S_SQR: begin
                p_s = step_s;
                y_s = y_r << 1;
                if (cnt_r == IDX_ZERO) begin
                    acc_s = step_s;
                    if (exp_r[idx_r]) begin
                        x_s     = step_s;
                        y_s     = base_r;
                        p_s     = ZERO;
                        cnt_s   = TOP_IDX;
                        state_s = S_MUL;
                    end else begin
                        state_s = S_NEXT;
                    end
                end else begin
                    cnt_s = cnt_r - IDX_ONE;
                end
            end

            S_MUL: begin
                p_s = step_s;
                y_s = y_r << 1;
                if (cnt_r == IDX_ZERO) begin
                    acc_s   = step_s;
                    state_s = S_NEXT;
                end else begin
                    cnt_s = cnt_r - IDX_ONE;
                end
            end

            S_NEXT: begin
                if (idx_r == IDX_ZERO) begin
                    result_s = acc_r;
                    done_s   = 1'b1;
                    state_s  = S_DONE;
                end else begin
                    idx_s   = idx_r - IDX_ONE;
                    x_s     = acc_r;
                    y_s     = acc_r;
                    p_s     = ZERO;
                    cnt_s   = TOP_IDX;
                    state_s = S_SQR;
                end
            end

            S_DONE: begin
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end

            default: begin
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Self-checking bench for rsa_modexp_core: directed RSA vectors, boundary
// operands, illegal operands, ignored starts, mid-operation reset and
// randomized operands against a plain-arithmetic reference model.

module tb_rsa_modexp_core;

    logic         clk = 1'b0;
    logic         reset = 1'b0;

    logic         start16 = 1'b0;
    logic [15:0]  msg16 = 16'd0;
    logic [15:0]  exp16 = 16'd0;
    logic [15:0]  n16 = 16'd0;
    logic [15:0]  result16;
    logic         done16, busy16, error16;

    logic         start128 = 1'b0;
    logic [127:0] msg128 = 128'd0;
    logic [127:0] exp128 = 128'd0;
    logic [127:0] n128 = 128'd0;
    logic [127:0] result128;
    logic         done128, busy128, error128;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rsa_modexp_core #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16),
        .message(msg16), .exponent(exp16), .n(n16),
        .result(result16), .done(done16), .busy(busy16), .error(error16)
    );

    rsa_modexp_core #(.WIDTH(128)) u_dut128 (
        .clk(clk), .reset(reset), .start(start128),
        .message(msg128), .exponent(exp128), .n(n128),
        .result(result128), .done(done128), .busy(busy128), .error(error128)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: right-to-left binary exponentiation with native arithmetic.
    function automatic longint unsigned ref_pow(input longint unsigned m,
                                                input longint unsigned e,
                                                input longint unsigned nn);
        longint unsigned r, b;
        r = 64'd1 % nn;
        b = m % nn;
        for (int i = 0; i < 64; i++) begin
            if (((e >> i) & 64'd1) == 64'd1) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r;
    endfunction

    function automatic int ref_lat(input int w, input longint unsigned e);
        int pc;
        pc = 0;
        for (int i = 0; i < 64; i++) pc += int'((e >> i) & 64'd1);
        return 2 + w * (w + 1) + w * pc;
    endfunction

    // Start one operation on the 16-bit core; cyc is the cycle done was seen.
    task automatic run16(input logic [15:0] m, input logic [15:0] e, input logic [15:0] nn,
                         output logic [15:0] res, output logic er, output int cyc);
        @(negedge clk);
        start16 = 1'b1; msg16 = m; exp16 = e; n16 = nn;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        cyc = 1;
        while (done16 !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        res = result16;
        er  = error16;
    endtask

    task automatic run128(input logic [127:0] m, input logic [127:0] e, input logic [127:0] nn,
                          output logic [127:0] res, output int cyc);
        @(negedge clk);
        start128 = 1'b1; msg128 = m; exp128 = e; n128 = nn;
        @(posedge clk);
        @(negedge clk);
        start128 = 1'b0;
        cyc = 1;
        while (done128 !== 1'b1 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
        end
        res = result128;
    endtask

    initial begin
        logic [15:0]  res;
        logic [127:0] res128;
        logic         er;
        int           cyc;
        logic         flag;
        logic [15:0]  rn, rm, re;

        #1 reset = 1'b1;
        #1;
        check("reset_result", {112'd0, result16}, 128'd0);
        check("reset_done",   {127'd0, done16},   128'd0);
        check("reset_busy",   {127'd0, busy16},   128'd0);
        check("reset_error",  {127'd0, error16},  128'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Textbook RSA pair, encrypt then decrypt.
        run16(16'd920, 16'd17, 16'd2773, res, er, cyc);
        check("enc16_result", {112'd0, res}, 128'd948);
        check("enc16_error",  {127'd0, er},  128'd0);
        check("enc16_cycle",  128'(cyc),     128'(ref_lat(16, 64'd17)));
        @(negedge clk);
        check("enc16_done_pulse", {127'd0, done16}, 128'd0);
        check("enc16_busy_fall",  {127'd0, busy16}, 128'd0);
        check("enc16_result_hold", {112'd0, result16}, 128'd948);
        run16(16'd948, 16'd157, 16'd2773, res, er, cyc);
        check("dec16_result", {112'd0, res}, 128'd920);
        check("dec16_cycle",  128'(cyc),     128'd354);

        // Boundary operands.
        run16(16'd920, 16'd0, 16'd2773, res, er, cyc);
        check("exp0_result", {112'd0, res}, 128'd1);
        run16(16'd0, 16'd5, 16'd2773, res, er, cyc);
        check("msg0_result", {112'd0, res}, 128'd0);
        run16(16'd1234, 16'd1, 16'd2773, res, er, cyc);
        check("exp1_result", {112'd0, res}, 128'd1234);
        run16(16'd0, 16'd0, 16'd1, res, er, cyc);
        check("n1_result", {112'd0, res}, 128'd0);
        check("n1_error",  {127'd0, er},  128'd0);

        // Illegal operands, then a legal start clears error.
        run16(16'd3000, 16'd17, 16'd2773, res, er, cyc);
        check("illegal_error",  {127'd0, er},  128'd1);
        check("illegal_result", {112'd0, res}, 128'd0);
        check("illegal_cycle",  128'(cyc),     128'd2);
        run16(16'd5, 16'd3, 16'd0, res, er, cyc);
        check("n0_error", {127'd0, er}, 128'd1);
        run16(16'd920, 16'd17, 16'd2773, res, er, cyc);
        check("clear_error",  {127'd0, er},  128'd0);
        check("clear_result", {112'd0, res}, 128'd948);

        // Starts during a busy operation are ignored.
        @(negedge clk);
        start16 = 1'b1; msg16 = 16'd920; exp16 = 16'd17; n16 = 16'd2773;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        cyc = 1;
        flag = 1'b0;
        while (done16 !== 1'b1 && cyc < 2000) begin
            if (busy16 !== 1'b1) flag = 1'b1;
            if (cyc == 50 || cyc == 200) begin
                start16 = 1'b1; msg16 = 16'd5; exp16 = 16'd3;
            end else begin
                start16 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check("ignore_result", {112'd0, result16}, 128'd948);
        check("ignore_cycle",  128'(cyc),          128'd306);
        check("ignore_busy_continuous", {127'd0, flag}, 128'd0);
        check("ignore_busy_at_done", {127'd0, busy16}, 128'd1);

        // Reset mid-operation aborts immediately with no done.
        @(negedge clk);
        start16 = 1'b1; msg16 = 16'd920; exp16 = 16'd17; n16 = 16'd2773;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        cyc = 1;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        reset = 1'b1;
        #1;
        check("abort_result", {112'd0, result16}, 128'd0);
        check("abort_busy",   {127'd0, busy16},   128'd0);
        check("abort_done",   {127'd0, done16},   128'd0);
        check("abort_error",  {127'd0, error16},  128'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        flag = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (done16 === 1'b1 || busy16 === 1'b1) flag = 1'b1;
        end
        check("abort_no_done", {127'd0, flag}, 128'd0);
        run16(16'd920, 16'd17, 16'd2773, res, er, cyc);
        check("after_abort_result", {112'd0, res}, 128'd948);
        check("after_abort_cycle",  128'(cyc),     128'd306);

        // Randomized operands against the reference model.
        for (int k = 0; k < 8; k++) begin
            rn = 16'($urandom_range(65535, 2));
            rm = 16'($urandom_range(int'(rn) - 1, 0));
            re = 16'($urandom);
            run16(rm, re, rn, res, er, cyc);
            check("rand_result", {112'd0, res}, 128'(ref_pow(64'(rm), 64'(re), 64'(rn))));
            check("rand_cycle",  128'(cyc),     128'(ref_lat(16, 64'(re))));
        end

        // Wide instance with the same small operands.
        run128(128'd920, 128'd17, 128'd2773, res128, cyc);
        check("enc128_result", res128,     128'd948);
        check("enc128_cycle",  128'(cyc),  128'd16770);
        run128(128'd948, 128'd157, 128'd2773, res128, cyc);
        check("dec128_result", res128,     128'd920);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
